decode_issue_unit: RTL and testbench

//  Parametrised successor of the single-slot decode stage: buffers fetched instructions in an
//  IQ_DEPTH FIFO, decodes the head, reads Reg, predicts control flow and issues one instruction
//  per cycle to RoB + RS or RoB + LSB. Sits between Fetcher and RoB/RS/LSB/Reg; stalls per target, flushes on rob_clear.

---
 rtl/decode_issue_unit_pkg.sv | 64 ++++++
 rtl/decode_issue_unit_branch_predictor.sv | 59 +++++
 rtl/decode_issue_unit.sv | 194 +++++++++++++++++++
 tb/tb_decode_issue_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_unit_pkg.sv
// Shared decode definitions for the decode/issue slice: opcode constants,
// default RoB tag width and the immediate generator.
// Compile-time macro ROB_SIZE_WIDTH may be defined externally to override
// the default RoB tag width.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package decode_issue_unit_pkg;

    localparam int unsigned DEF_ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH;
    localparam int unsigned XLEN               = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LD     = 7'b0000011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;

    // Decoded view of the queue head
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            is_ls;
        logic            no_rs2;
        logic            is_jal;
        logic            is_br;
    } decode_t;

    // Sign-extended immediate per instruction format; R-type and unknown give 0
    function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] instr);
        logic [XLEN-1:0] res;
        res = '0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC: res = {instr[31:12], 12'b0};
            OP_JAL:           res = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_JALR, OP_LD,
            OP_I:             res = {{20{instr[31]}}, instr[31:20]};
            OP_B:             res = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_S:             res = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            default:          res = '0;
        endcase
        return res;
    endfunction

    function automatic decode_t decode(input logic [XLEN-1:0] instr);
        decode_t d;
        logic [6:0] opc;
        opc      = instr[6:0];
        d.imm    = gen_imm(instr);
        d.is_ls  = (opc == OP_LD) || (opc == OP_S);
        d.is_jal = (opc == OP_JAL);
        d.is_br  = (opc == OP_B);
        d.no_rs2 = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL) ||
                   (opc == OP_JALR) || (opc == OP_LD) || (opc == OP_I);
        d.rd     = (d.is_br || (opc == OP_S)) ? 5'd0 : instr[11:7];
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_unit_branch_predictor.sv
// Conditional-branch direction predictor.
// Macro BHT_EN: 2^INDEX_W x 2-bit saturating counters indexed by pc[INDEX_W+1:2],
// trained from committed branches; predicts taken iff counter[1]. Without
// BHT_EN the prediction is static backward-taken (taken_c = backward) and the
// training port is ignored.
// Ports: clk, rst (sync, active-high), rdy (freeze), rd_pc/backward -> taken_c
// (combinational), upd_valid/upd_pc/upd_taken (training).
module decode_issue_unit_branch_predictor #(
    parameter int unsigned INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] rd_pc,
    input  logic        backward,
    output logic        taken_c,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);

`ifdef BHT_EN
    localparam int unsigned ENTRIES = 2 ** INDEX_W;

    logic [1:0]         bht [ENTRIES];
    logic [INDEX_W-1:0] rd_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic               unused_bits;

    assign rd_idx      = rd_pc[INDEX_W+1:2];
    assign upd_idx     = upd_pc[INDEX_W+1:2];
    assign unused_bits = ^{backward, rd_pc[31:INDEX_W+2], rd_pc[1:0],
                           upd_pc[31:INDEX_W+2], upd_pc[1:0]};

    // Read is from the pre-update array, so a same-index update is not forwarded
    assign taken_c = bht[rd_idx][1];

    // Saturating counter training; reset to weakly not-taken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                bht[i] <= 2'b01;
            end
        end else if (rdy && upd_valid) begin
            if (upd_taken) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{clk, rst, rdy, rd_pc, upd_valid, upd_pc, upd_taken};
    assign taken_c     = backward;
`endif

endmodule

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: IQ_DEPTH-entry instruction queue fed by the fetcher,
// decode of the queue head, register-file lookup, control-flow prediction and
// single-instruction issue to RoB + RS or RoB + LSB.
// Optional macro BHT_EN selects a trained BHT branch predictor; otherwise
// conditional branches use static backward-taken prediction.
// Ports:
//   clk, rst (sync active-high), rdy (global enable, low freezes state)
//   rob_full/rs_full/lsb_full: per-target back-pressure; rob_clear: flush
//   instr_valid/instr_in/instr_addr_in: fetch push; iq_full: fetch must hold
//   redirect_valid/redirect_pc: one-cycle redirect on predicted-taken issue
//   reg_id1/2 (combinational from head), reg_value*/has_dep*/v_rob_id*_in: Reg
//   rd_rob_id_in: tag the RoB will allocate
//   instr_issued, to_lsb and the registered issue payload (*_out, imm, rd, pred_*)
//   commit_br_*: branch-outcome training from the RoB
module decode_issue_unit
    import decode_issue_unit_pkg::*;
#(
    parameter int unsigned IQ_DEPTH        = 4,
    parameter int unsigned ROB_SIZE_WIDTH  = decode_issue_unit_pkg::DEF_ROB_SIZE_WIDTH,
    parameter int unsigned BHT_INDEX_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rob_full,
    input  logic                      rs_full,
    input  logic                      lsb_full,
    input  logic                      rob_clear,
    input  logic                      instr_valid,
    input  logic [31:0]               instr_in,
    input  logic [31:0]               instr_addr_in,
    output logic                      iq_full,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic [4:0]                reg_id1,
    output logic [4:0]                reg_id2,
    input  logic [31:0]               reg_value1_in,
    input  logic [31:0]               reg_value2_in,
    input  logic                      has_dep1_in,
    input  logic                      has_dep2_in,
    input  logic [ROB_SIZE_WIDTH-1:0] v_rob_id1_in,
    input  logic [ROB_SIZE_WIDTH-1:0] v_rob_id2_in,
    input  logic [ROB_SIZE_WIDTH-1:0] rd_rob_id_in,
    output logic                      instr_issued,
    output logic                      to_lsb,
    output logic [31:0]               instr_out,
    output logic [31:0]               instr_addr_out,
    output logic [2:0]                op_out,
    output logic [6:0]                instr_type_out,
    output logic [31:0]               imm,
    output logic [4:0]                rd,
    output logic [31:0]               reg_value1_out,
    output logic [31:0]               reg_value2_out,
    output logic                      has_dep1_out,
    output logic                      has_dep2_out,
    output logic [ROB_SIZE_WIDTH-1:0] v_rob_id1_out,
    output logic [ROB_SIZE_WIDTH-1:0] v_rob_id2_out,
    output logic [ROB_SIZE_WIDTH-1:0] rd_rob_id_out,
    output logic                      pred_taken,
    output logic [31:0]               pred_pc,
    input  logic                      commit_br_valid,
    input  logic [31:0]               commit_br_pc,
    input  logic                      commit_br_taken
);

    localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      mem_instr [IQ_DEPTH];
    logic [31:0]      mem_addr  [IQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        head_valid;
    decode_t     dec;
    logic        bp_taken_c;
    logic        pred_taken_c;
    logic [31:0] target_c;
    logic [31:0] seq_pc_c;
    logic        push_c;
    logic        issue_c;
    logic        redirect_c;

    // Queue head decode and issue decision
    assign head_instr = mem_instr[head];
    assign head_pc    = mem_addr[head];
    assign head_valid = (count != '0);
    assign dec        = decode(head_instr);

    assign iq_full = (count == CNT_W'(IQ_DEPTH));
    assign reg_id1 = head_valid ? head_instr[19:15] : 5'd0;
    assign reg_id2 = head_valid ? head_instr[24:20] : 5'd0;

    assign push_c       = instr_valid && !iq_full;
    assign issue_c      = head_valid && !rob_full && (dec.is_ls ? !lsb_full : !rs_full);
    assign pred_taken_c = dec.is_jal || (dec.is_br && bp_taken_c);
    assign target_c     = head_pc + dec.imm;
    assign seq_pc_c     = head_pc + 32'd4;
    assign redirect_c   = issue_c && pred_taken_c;

    decode_issue_unit_branch_predictor #(
        .INDEX_W (BHT_INDEX_WIDTH)
    ) u_bp (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_pc     (head_pc),
        .backward  (dec.imm[31]),
        .taken_c   (bp_taken_c),
        .upd_valid (commit_br_valid),
        .upd_pc    (commit_br_pc),
        .upd_taken (commit_br_taken)
    );

    // Queue storage; a write only matters when tail advances
    always_ff @(posedge clk) begin
        if (!rst && rdy && push_c) begin
            mem_instr[tail] <= instr_in;
            mem_addr[tail]  <= instr_addr_in;
        end
    end

    // Queue pointers and registered issue outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            instr_issued   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            to_lsb         <= 1'b0;
            instr_out      <= '0;
            instr_addr_out <= '0;
            op_out         <= '0;
            instr_type_out <= '0;
            imm            <= '0;
            rd             <= '0;
            reg_value1_out <= '0;
            reg_value2_out <= '0;
            has_dep1_out   <= 1'b0;
            has_dep2_out   <= 1'b0;
            v_rob_id1_out  <= '0;
            v_rob_id2_out  <= '0;
            rd_rob_id_out  <= '0;
            pred_taken     <= 1'b0;
            pred_pc        <= '0;
        end else if (rdy) begin
            if (rob_clear) begin
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                instr_issued   <= 1'b0;
                redirect_valid <= 1'b0;
            end else begin
                instr_issued   <= issue_c;
                redirect_valid <= redirect_c;
                if (redirect_c) begin
                    // Everything fetched behind a predicted-taken op is wrong-path
                    head        <= '0;
                    tail        <= '0;
                    count       <= '0;
                    redirect_pc <= target_c;
                end else begin
                    if (push_c)  tail <= tail + PTR_W'(1);
                    if (issue_c) head <= head + PTR_W'(1);
                    count <= count + CNT_W'(push_c) - CNT_W'(issue_c);
                end
                if (issue_c) begin
                    to_lsb         <= dec.is_ls;
                    instr_out      <= head_instr;
                    instr_addr_out <= head_pc;
                    op_out         <= head_instr[14:12];
                    instr_type_out <= head_instr[6:0];
                    imm            <= dec.imm;
                    rd             <= dec.rd;
                    reg_value1_out <= reg_value1_in;
                    has_dep1_out   <= has_dep1_in;
                    v_rob_id1_out  <= v_rob_id1_in;
                    reg_value2_out <= dec.no_rs2 ? dec.imm : reg_value2_in;
                    has_dep2_out   <= dec.no_rs2 ? 1'b0 : has_dep2_in;
                    v_rob_id2_out  <= dec.no_rs2 ? '0 : v_rob_id2_in;
                    rd_rob_id_out  <= rd_rob_id_in;
                    pred_taken     <= pred_taken_c;
                    pred_pc        <= pred_taken_c ? target_c : seq_pc_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_unit.sv
module tb_decode_issue_unit;

    localparam int IQ_DEPTH = 4;
    localparam int RSW      = int'(decode_issue_unit_pkg::DEF_ROB_SIZE_WIDTH);

    logic           clk;
    logic           rst, rdy, rob_full, rs_full, lsb_full, rob_clear;
    logic           instr_valid;
    logic [31:0]    instr_in, instr_addr_in;
    logic           iq_full, redirect_valid;
    logic [31:0]    redirect_pc;
    logic [4:0]     reg_id1, reg_id2;
    logic [31:0]    reg_value1_in, reg_value2_in;
    logic           has_dep1_in, has_dep2_in;
    logic [RSW-1:0] v_rob_id1_in, v_rob_id2_in, rd_rob_id_in;
    logic           instr_issued, to_lsb;
    logic [31:0]    instr_out, instr_addr_out;
    logic [2:0]     op_out;
    logic [6:0]     instr_type_out;
    logic [31:0]    imm;
    logic [4:0]     rd;
    logic [31:0]    reg_value1_out, reg_value2_out;
    logic           has_dep1_out, has_dep2_out;
    logic [RSW-1:0] v_rob_id1_out, v_rob_id2_out, rd_rob_id_out;
    logic           pred_taken;
    logic [31:0]    pred_pc;
    logic           commit_br_valid, commit_br_taken;
    logic [31:0]    commit_br_pc;

    int checks = 0;
    int errors = 0;

    decode_issue_unit #(.IQ_DEPTH(IQ_DEPTH), .ROB_SIZE_WIDTH(RSW), .BHT_INDEX_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_full(rob_full), .rs_full(rs_full),
        .lsb_full(lsb_full), .rob_clear(rob_clear), .instr_valid(instr_valid),
        .instr_in(instr_in), .instr_addr_in(instr_addr_in), .iq_full(iq_full),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .reg_id1(reg_id1), .reg_id2(reg_id2),
        .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
        .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
        .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in),
        .rd_rob_id_in(rd_rob_id_in), .instr_issued(instr_issued), .to_lsb(to_lsb),
        .instr_out(instr_out), .instr_addr_out(instr_addr_out), .op_out(op_out),
        .instr_type_out(instr_type_out), .imm(imm), .rd(rd),
        .reg_value1_out(reg_value1_out), .reg_value2_out(reg_value2_out),
        .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
        .v_rob_id1_out(v_rob_id1_out), .v_rob_id2_out(v_rob_id2_out),
        .rd_rob_id_out(rd_rob_id_out), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .commit_br_valid(commit_br_valid), .commit_br_pc(commit_br_pc),
        .commit_br_taken(commit_br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t m_q[$];
    int   m_bht[64];

    logic           e_issued, e_to_lsb, e_hd1, e_hd2, e_pt, e_rv;
    logic [31:0]    e_instr, e_addr, e_imm, e_rv1, e_rv2, e_ppc, e_rpc;
    logic [2:0]     e_op;
    logic [6:0]     e_type;
    logic [4:0]     e_rd;
    logic [RSW-1:0] e_vr1, e_vr2, e_rdrob;

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [31:0] sx;
        sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        case (ins[6:0])
            7'h37, 7'h17:      return ins & 32'hFFFF_F000;
            7'h6F:             return (sx & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
                                      ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
            7'h67, 7'h03, 7'h13: return (sx & 32'hFFFF_F000) | (ins >> 20);
            7'h63:             return (sx & 32'hFFFF_F000) | ((ins >> 20) & 32'h7E0) |
                                      ((ins >> 7) & 32'h1E) | ((ins << 4) & 32'h800);
            7'h23:             return (sx & 32'hFFFF_F000) | ((ins >> 20) & 32'hFE0) |
                                      ((ins >> 7) & 32'h1F);
            default:           return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void model_step();
        ent_t        h;
        logic [6:0]  opc;
        logic [31:0] im, tgt;
        logic        ls, nors2, taken, issue, push;
        int          idx;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            {e_issued, e_to_lsb, e_hd1, e_hd2, e_pt, e_rv} = '0;
            {e_instr, e_addr, e_imm, e_rv1, e_rv2, e_ppc, e_rpc} = '0;
            {e_op, e_type, e_rd, e_vr1, e_vr2, e_rdrob} = '0;
            return;
        end
        if (!rdy) return;
        if (rob_clear) begin
            m_q.delete();
            e_issued = 1'b0;
            e_rv     = 1'b0;
        end else begin
            push  = instr_valid && (m_q.size() < IQ_DEPTH);
            issue = 1'b0;
            taken = 1'b0;
            tgt   = 32'h0;
            if (m_q.size() > 0) begin
                h     = m_q[0];
                opc   = h.instr[6:0];
                ls    = (opc == 7'h03) || (opc == 7'h23);
                issue = !rob_full && (ls ? !lsb_full : !rs_full);
                if (issue) begin
                    im    = ref_imm(h.instr);
                    nors2 = (opc == 7'h37) || (opc == 7'h17) || (opc == 7'h6F) ||
                            (opc == 7'h67) || (opc == 7'h03) || (opc == 7'h13);
                    if (opc == 7'h6F) taken = 1'b1;
                    else if (opc == 7'h63) begin
`ifdef BHT_EN
                        taken = (m_bht[(h.pc >> 2) % 64] >= 2);
`else
                        taken = im[31];
`endif
                    end
                    tgt      = h.pc + im;
                    e_to_lsb = ls;
                    e_instr  = h.instr;
                    e_addr   = h.pc;
                    e_op     = h.instr[14:12];
                    e_type   = opc;
                    e_imm    = im;
                    e_rd     = ((opc == 7'h63) || (opc == 7'h23)) ? 5'd0 : h.instr[11:7];
                    e_rv1    = reg_value1_in;
                    e_hd1    = has_dep1_in;
                    e_vr1    = v_rob_id1_in;
                    e_rv2    = nors2 ? im : reg_value2_in;
                    e_hd2    = nors2 ? 1'b0 : has_dep2_in;
                    e_vr2    = nors2 ? '0 : v_rob_id2_in;
                    e_rdrob  = rd_rob_id_in;
                    e_pt     = taken;
                    e_ppc    = taken ? tgt : h.pc + 32'd4;
                end
            end
            e_issued = issue;
            e_rv     = issue && taken;
            if (e_rv) e_rpc = tgt;
            if (issue && taken) m_q.delete();
            else begin
                if (issue) void'(m_q.pop_front());
                if (push) m_q.push_back('{instr_in, instr_addr_in});
            end
        end
`ifdef BHT_EN
        if (commit_br_valid) begin
            idx = (commit_br_pc >> 2) % 64;
            if (commit_br_taken && m_bht[idx] < 3) m_bht[idx]++;
            else if (!commit_br_taken && m_bht[idx] > 0) m_bht[idx]--;
        end
`else
        idx = 0;
`endif
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; rdy = 1'b1; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        rob_clear = 1'b0; instr_valid = 1'b0; instr_in = '0; instr_addr_in = '0;
        reg_value1_in = '0; reg_value2_in = '0; has_dep1_in = 1'b0; has_dep2_in = 1'b0;
        v_rob_id1_in = '0; v_rob_id2_in = '0; rd_rob_id_in = '0;
        commit_br_valid = 1'b0; commit_br_pc = '0; commit_br_taken = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int rdn, input int rs1, input int val);
        return {12'(val), 5'(rs1), 3'b000, 5'(rdn), 7'h13};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        rst = 1'b1; instr_valid = 1'b1; instr_in = addi(3, 4, 7);
        tick();
        tick();
        set_idle();
        checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL reset_issued: got %b expected 0", instr_issued); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", redirect_valid); end
        checks++; if (iq_full !== 1'b0) begin errors++; $display("FAIL reset_iq_full: got %b expected 0", iq_full); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
        checks++; if (pred_pc !== 32'h0) begin errors++; $display("FAIL reset_pred_pc: got %h expected 0", pred_pc); end
        checks++; if (reg_id1 !== 5'd0) begin errors++; $display("FAIL reset_reg_id1: got %0d expected 0", reg_id1); end
    endtask

    task automatic test_addi();
        set_idle();
        instr_valid = 1'b1; instr_in = 32'h0050_0093; instr_addr_in = 32'h0;
        tick();
        checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL addi_push_cycle: got %b expected 0", instr_issued); end
        instr_valid = 1'b0; reg_value2_in = 32'hDEAD_BEEF;
        tick();
        checks++; if (instr_issued !== 1'b1) begin errors++; $display("FAIL addi_issued: got %b expected 1", instr_issued); end
        checks++; if (rd !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0d expected 1", rd); end
        checks++; if (reg_value2_out !== 32'd5) begin errors++; $display("FAIL addi_rv2: got %h expected 5", reg_value2_out); end
        checks++; if (to_lsb !== 1'b0) begin errors++; $display("FAIL addi_to_lsb: got %b expected 0", to_lsb); end
        checks++; if (pred_pc !== 32'd4 || pred_taken !== 1'b0) begin errors++; $display("FAIL addi_pred: got %b/%h expected 0/4", pred_taken, pred_pc); end
        tick();
        checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL addi_one_cycle: got %b expected 0", instr_issued); end
    endtask

    task automatic test_back_to_back();
        set_idle();
        rs_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; instr_in = addi(i + 1, 0, i); instr_addr_in = 32'h200 + 32'(4 * i);
            checks++; if (iq_full !== (i == 4)) begin errors++; $display("FAIL b2b_iq_full_%0d: got %b expected %b", i, iq_full, i == 4); end
            tick();
            checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL b2b_stalled_%0d: got %b expected 0", i, instr_issued); end
        end
        instr_valid = 1'b0; rs_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (instr_issued !== 1'b1 || rd !== 5'(i + 1)) begin errors++; $display("FAIL b2b_issue_%0d: got %b rd %0d expected 1 rd %0d", i, instr_issued, rd, i + 1); end
        end
        tick();
        checks++; if (instr_issued !== 1'b0 || iq_full !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b/%b expected 0/0", instr_issued, iq_full); end
    endtask

    task automatic test_lsb_stall();
        set_idle();
        lsb_full = 1'b1;
        instr_valid = 1'b1; instr_in = 32'h0020_A423; instr_addr_in = 32'h300;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL sw_stall_%0d: got %b expected 0", i, instr_issued); end
        end
        lsb_full = 1'b0; reg_value2_in = 32'h1234_5678;
        tick();
        checks++; if (instr_issued !== 1'b1 || to_lsb !== 1'b1) begin errors++; $display("FAIL sw_issue: got %b/%b expected 1/1", instr_issued, to_lsb); end
        checks++; if (rd !== 5'd0 || imm !== 32'd8) begin errors++; $display("FAIL sw_fields: got rd %0d imm %h expected rd 0 imm 8", rd, imm); end
        checks++; if (reg_value2_out !== 32'h1234_5678) begin errors++; $display("FAIL sw_rv2: got %h expected 12345678", reg_value2_out); end
    endtask

    task automatic test_redirect();
        set_idle();
        rob_full = 1'b1;
        instr_valid = 1'b1; instr_in = 32'h0100_00EF; instr_addr_in = 32'h100;
        tick();
        instr_in = addi(2, 0, 1); instr_addr_in = 32'h104;
        tick();
        instr_in = addi(3, 0, 1); instr_addr_in = 32'h108;
        tick();
        rob_full = 1'b0; instr_in = addi(4, 0, 1); instr_addr_in = 32'h10C;
        tick();
        instr_valid = 1'b0;
        checks++; if (instr_issued !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL jal_issue: got %b/%b expected 1/1", instr_issued, redirect_valid); end
        checks++; if (redirect_pc !== 32'h110) begin errors++; $display("FAIL jal_redirect_pc: got %h expected 110", redirect_pc); end
        checks++; if (pred_taken !== 1'b1 || pred_pc !== 32'h110) begin errors++; $display("FAIL jal_pred: got %b/%h expected 1/110", pred_taken, pred_pc); end
        checks++; if (rd !== 5'd1 || iq_full !== 1'b0) begin errors++; $display("FAIL jal_rd_full: got %0d/%b expected 1/0", rd, iq_full); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_issued !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL jal_after_%0d: got %b/%b expected 0/0", i, instr_issued, redirect_valid); end
        end
    endtask

    task automatic test_clear();
        set_idle();
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1'b1; instr_in = addi(5, 3, i); instr_addr_in = 32'h400 + 32'(4 * i);
            tick();
        end
        checks++; if (reg_id1 !== 5'd3) begin errors++; $display("FAIL clr_reg_id1: got %0d expected 3", reg_id1); end
        rob_full = 1'b0; rob_clear = 1'b1; instr_in = addi(6, 0, 0); instr_addr_in = 32'h40C;
        tick();
        checks++; if (instr_issued !== 1'b0 || iq_full !== 1'b0) begin errors++; $display("FAIL clr_next: got %b/%b expected 0/0", instr_issued, iq_full); end
        checks++; if (reg_id1 !== 5'd0) begin errors++; $display("FAIL clr_empty: got %0d expected 0", reg_id1); end
        rob_clear = 1'b0; instr_in = addi(7, 0, 0); instr_addr_in = 32'h500;
        tick();
        checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL clr_push_cycle: got %b expected 0", instr_issued); end
        instr_valid = 1'b0;
        tick();
        checks++; if (instr_issued !== 1'b1 || rd !== 5'd7) begin errors++; $display("FAIL clr_push_after: got %b rd %0d expected 1 rd 7", instr_issued, rd); end
        tick();
    endtask

    task automatic test_rdy_freeze();
        set_idle();
        instr_valid = 1'b1; instr_in = addi(9, 0, 9); instr_addr_in = 32'h600;
        tick();
        instr_valid = 1'b0;
        tick();
        rdy = 1'b0; rob_clear = 1'b1; instr_valid = 1'b1; instr_in = addi(10, 0, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (instr_issued !== 1'b1 || rd !== 5'd9) begin errors++; $display("FAIL rdy_hold_%0d: got %b rd %0d expected 1 rd 9", i, instr_issued, rd); end
        end
        checks++; if (reg_id2 !== 5'd0) begin errors++; $display("FAIL rdy_no_push: got %0d expected 0", reg_id2); end
        set_idle();
        tick();
        checks++; if (instr_issued !== 1'b0) begin errors++; $display("FAIL rdy_release: got %b expected 0", instr_issued); end
    endtask

    task automatic test_branch_pred();
        logic exp_fwd, exp_back;
`ifdef BHT_EN
        exp_fwd = 1'b1; exp_back = 1'b0;
`else
        exp_fwd = 1'b0; exp_back = 1'b1;
`endif
        set_idle();
        commit_br_valid = 1'b1; commit_br_pc = 32'h40; commit_br_taken = 1'b1;
        tick();
        tick();
        commit_br_valid = 1'b0;
        instr_valid = 1'b1; instr_in = 32'h0000_0463; instr_addr_in = 32'h40;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++; if (instr_issued !== 1'b1 || pred_taken !== exp_fwd) begin errors++; $display("FAIL beq_fwd_pred: got %b/%b expected 1/%b", instr_issued, pred_taken, exp_fwd); end
        checks++; if (pred_pc !== (exp_fwd ? 32'h48 : 32'h44)) begin errors++; $display("FAIL beq_fwd_pc: got %h expected %h", pred_pc, exp_fwd ? 32'h48 : 32'h44); end
        checks++; if (redirect_valid !== exp_fwd) begin errors++; $display("FAIL beq_fwd_redirect: got %b expected %b", redirect_valid, exp_fwd); end
        instr_valid = 1'b1; instr_in = 32'hFE00_0CE3; instr_addr_in = 32'h80;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++; if (pred_taken !== exp_back || imm !== 32'hFFFF_FFF8) begin errors++; $display("FAIL beq_back_pred: got %b imm %h expected %b imm fffffff8", pred_taken, imm, exp_back); end
        checks++; if (pred_pc !== (exp_back ? 32'h78 : 32'h84)) begin errors++; $display("FAIL beq_back_pc: got %h expected %h", pred_pc, exp_back ? 32'h78 : 32'h84); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h13, 7'h23, 7'h33, 7'h7F};
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 9)];
        return ins;
    endfunction

    task automatic test_random();
        logic [111:0]       got_p, exp_p;
        logic [66+3*RSW-1:0] got_o, exp_o;
        logic [65:0]        got_c, exp_c;
        logic [4:0]         exp_id1, exp_id2;
        set_idle();
        for (int c = 0; c < 3000; c++) begin
            rdy             = ($urandom_range(0, 9) != 0);
            rob_full        = ($urandom_range(0, 4) == 0);
            rs_full         = ($urandom_range(0, 3) == 0);
            lsb_full        = ($urandom_range(0, 3) == 0);
            rob_clear       = ($urandom_range(0, 24) == 0);
            instr_valid     = ($urandom_range(0, 2) != 0);
            instr_in        = rand_instr();
            instr_addr_in   = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                                          : (32'($urandom_range(0, 127)) << 2);
            reg_value1_in   = $urandom;
            reg_value2_in   = $urandom;
            has_dep1_in     = 1'($urandom);
            has_dep2_in     = 1'($urandom);
            v_rob_id1_in    = RSW'($urandom);
            v_rob_id2_in    = RSW'($urandom);
            rd_rob_id_in    = RSW'($urandom);
            commit_br_valid = ($urandom_range(0, 2) == 0);
            commit_br_pc    = 32'($urandom_range(0, 127)) << 2;
            commit_br_taken = 1'($urandom);
            exp_id1 = (m_q.size() > 0) ? m_q[0].instr[19:15] : 5'd0;
            exp_id2 = (m_q.size() > 0) ? m_q[0].instr[24:20] : 5'd0;
            checks++; if (iq_full !== (m_q.size() == IQ_DEPTH)) begin errors++; $display("FAIL rnd_iq_full c%0d: got %b expected %b", c, iq_full, m_q.size() == IQ_DEPTH); end
            checks++; if ({reg_id1, reg_id2} !== {exp_id1, exp_id2}) begin errors++; $display("FAIL rnd_reg_id c%0d: got %0d/%0d expected %0d/%0d", c, reg_id1, reg_id2, exp_id1, exp_id2); end
            tick();
            checks++; if (instr_issued !== e_issued) begin errors++; $display("FAIL rnd_issued c%0d: got %b expected %b", c, instr_issued, e_issued); end
            got_p = {to_lsb, instr_out, instr_addr_out, op_out, instr_type_out, imm, rd};
            exp_p = {e_to_lsb, e_instr, e_addr, e_op, e_type, e_imm, e_rd};
            checks++; if (got_p !== exp_p) begin errors++; $display("FAIL rnd_payload c%0d: got %h expected %h", c, got_p, exp_p); end
            got_o = {reg_value1_out, reg_value2_out, has_dep1_out, has_dep2_out, v_rob_id1_out, v_rob_id2_out, rd_rob_id_out};
            exp_o = {e_rv1, e_rv2, e_hd1, e_hd2, e_vr1, e_vr2, e_rdrob};
            checks++; if (got_o !== exp_o) begin errors++; $display("FAIL rnd_operands c%0d: got %h expected %h", c, got_o, exp_o); end
            got_c = {pred_taken, pred_pc, redirect_valid, redirect_pc};
            exp_c = {e_pt, e_ppc, e_rv, e_rpc};
            checks++; if (got_c !== exp_c) begin errors++; $display("FAIL rnd_control c%0d: got %h expected %h", c, got_c, exp_c); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_lsb_stall();
        test_redirect();
        test_clear();
        test_rdy_freeze();
        test_branch_pred();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
